// File: rtl/dfp_line_memory_pkg.sv
// Shared types and constants for the dfp line memory: FSM states, latency
// counter width and the byte-offset width used for line-index extraction.
package dfp_line_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dfp_mem_state_t;

    localparam int DFP_LAT_BITS = 4;
    // 256-bit line = 32 bytes, so address bits [4:0] select a byte inside the line
    localparam int OFFSET_BITS  = 5;

    function automatic logic [DFP_LAT_BITS-1:0] lat_load(input int lat);
        return DFP_LAT_BITS'(lat - 1);
    endfunction

endpackage

// File: rtl/dfp_line_memory_store.sv
// Single-port line array with per-line valid bits; the read is registered so it
// lands in the cycle after the access edge.
module dfp_line_memory_store
    import dfp_line_memory_pkg::*;
#(
    parameter int LINE_BITS  = 256,
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [INDEX_BITS-1:0] idx_i,
    input  logic [LINE_BITS-1:0]  wdata_i,
    output logic [LINE_BITS-1:0]  rdata_o
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINE_BITS-1:0] mem_q [LINES];
    logic [LINES-1:0]     valid_q;
    logic [LINE_BITS-1:0] rdata_q;

    // storage data is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // never-written lines read as zero, so unreset storage is never observed
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i && valid_q[idx_i]) begin
            rdata_q <= mem_q[idx_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dfp_line_memory.sv
// Cacheline-granular responder for the cache dfp port: fixed-latency line
// read/write with a sticky protocol-violation flag.
module dfp_line_memory
    import dfp_line_memory_pkg::*;
#(
    parameter int LINE_BITS     = 256,
    parameter int ADDR_BITS     = 32,
    parameter int INDEX_BITS    = 8,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [ADDR_BITS-1:0] dfp_addr_i,
    input  logic                 dfp_read_i,
    input  logic                 dfp_write_i,
    input  logic [LINE_BITS-1:0] dfp_wdata_i,
    output logic [LINE_BITS-1:0] dfp_rdata_o,
    output logic                 dfp_resp_o,
    output logic                 proto_err_o
);

    localparam logic [DFP_LAT_BITS-1:0] RD_LOAD = lat_load(READ_LATENCY);
    localparam logic [DFP_LAT_BITS-1:0] WR_LOAD = lat_load(WRITE_LATENCY);

    dfp_mem_state_t          state_q, state_d;
    logic [DFP_LAT_BITS-1:0] cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic                    is_wr_q, is_wr_d;
    logic [LINE_BITS-1:0]    wdata_q, wdata_d;
    logic                    err_q, err_d;

    logic [INDEX_BITS-1:0]   req_idx;
    logic                    req_level;
    logic                    store_we;
    logic                    store_re;
    logic [LINE_BITS-1:0]    store_rdata;
    logic                    unused_addr_bits;

    // upper bits alias silently; offset bits are meaningless at line granularity
    assign req_idx          = dfp_addr_i[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign unused_addr_bits = ^{dfp_addr_i[ADDR_BITS-1:OFFSET_BITS+INDEX_BITS],
                                dfp_addr_i[OFFSET_BITS-1:0]};
    assign req_level        = is_wr_q ? dfp_write_i : dfp_read_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            is_wr_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            is_wr_q <= is_wr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        is_wr_d  = is_wr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        store_we = 1'b0;
        store_re = 1'b0;
        case (state_q)
            IDLE: begin
                if (dfp_write_i || dfp_read_i) begin
                    idx_d   = req_idx;
                    is_wr_d = dfp_write_i;
                    wdata_d = dfp_wdata_i;
                    cnt_d   = dfp_write_i ? WR_LOAD : RD_LOAD;
                    state_d = BUSY;
                    if (dfp_write_i && dfp_read_i) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // violations are flagged but the latched request still completes
                if (!req_level || (req_idx != idx_q)) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    store_we = is_wr_q;
                    store_re = !is_wr_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dfp_line_memory_store #(
        .LINE_BITS (LINE_BITS),
        .INDEX_BITS(INDEX_BITS)
    ) u_store (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .we_i   (store_we),
        .re_i   (store_re),
        .idx_i  (idx_q),
        .wdata_i(wdata_q),
        .rdata_o(store_rdata)
    );

    assign dfp_resp_o  = (state_q == RESP);
    assign dfp_rdata_o = (state_q == RESP) ? store_rdata : '0;
    assign proto_err_o = err_q;

endmodule

// File: tb/tb_dfp_line_memory.sv
// Randomized self-checking bench for dfp_line_memory with an edge-indexed
// behavioural model and a per-cycle output comparator.
module tb_dfp_line_memory;

    localparam int RL  = 4;
    localparam int WL  = 4;
    localparam int INF = 32'h7fff_ffff;

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic [31:0]  dfp_addr_i = '0;
    logic         dfp_read_i = 1'b0;
    logic         dfp_write_i = 1'b0;
    logic [255:0] dfp_wdata_i = '0;
    logic [255:0] dfp_rdata_o;
    logic         dfp_resp_o;
    logic         proto_err_o;

    dfp_line_memory #(
        .LINE_BITS(256), .ADDR_BITS(32), .INDEX_BITS(8),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .dfp_addr_i(dfp_addr_i),
        .dfp_read_i(dfp_read_i), .dfp_write_i(dfp_write_i),
        .dfp_wdata_i(dfp_wdata_i), .dfp_rdata_o(dfp_rdata_o),
        .dfp_resp_o(dfp_resp_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    // model: expectations are keyed by the number of rising edges seen so far
    int           edge_cnt = 0;
    int           resp_edge = -1;
    logic [255:0] resp_data = '0;
    int           err_edge = INF;
    int           idle_from = 0;
    logic [255:0] m_mem [256];
    bit           m_val [256];

    int checks = 0;
    int errors = 0;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    logic exp_resp;
    always @(negedge clk_i) begin
        exp_resp = (edge_cnt == resp_edge);
        check("resp", {255'd0, dfp_resp_o}, {255'd0, exp_resp});
        check("rdata", dfp_rdata_o, exp_resp ? resp_data : 256'd0);
        check("proto_err", {255'd0, proto_err_o}, {255'd0, (edge_cnt >= err_edge)});
    end

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> 5) % 256);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // called just after a negedge
    task automatic do_reset();
        #2;
        rst_n_i = 1'b0;
        dfp_read_i = 1'b0;
        dfp_write_i = 1'b0;
        resp_edge = -1;
        err_edge = INF;
        for (int i = 0; i < 256; i++) m_val[i] = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_resp", {255'd0, dfp_resp_o}, 256'd0);
        check("rst_rdata", dfp_rdata_o, 256'd0);
        check("rst_err", {255'd0, proto_err_o}, 256'd0);
        #2;
        rst_n_i = 1'b1;
        idle_from = edge_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            dfp_read_i = 1'b0;
            dfp_write_i = 1'b0;
        end
    endtask

    // ev: 0 none, 1 drop request, 2 change line index, 3 change offset/alias bits only
    task automatic txn(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [255:0] data, input int ev, input int ev_at,
                       input int rst_at, input bit chk_lit, input logic [255:0] lit,
                       input string nm);
        int n, lat, idx;
        bit seen;
        logic [255:0] rdat;
        @(negedge clk_i);
        while (edge_cnt < idle_from) @(negedge clk_i);
        n = edge_cnt + 1;
        dfp_addr_i = addr;
        dfp_write_i = wr;
        dfp_read_i = rd;
        dfp_wdata_i = data;
        idx = line_of(addr);
        lat = wr ? WL : RL;
        if (wr && rd && n < err_edge) err_edge = n;
        if (wr) begin
            m_mem[idx] = data;
            m_val[idx] = 1'b1;
            rdat = '0;
        end else begin
            rdat = m_val[idx] ? m_mem[idx] : 256'd0;
        end
        resp_edge = n + lat;
        resp_data = rdat;
        idle_from = n + lat + 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_i);
            if (ev != 0 && k == ev_at) begin
                case (ev)
                    1: begin
                        dfp_read_i = 1'b0;
                        dfp_write_i = 1'b0;
                        if (edge_cnt + 1 < err_edge) err_edge = edge_cnt + 1;
                    end
                    2: begin
                        dfp_addr_i = dfp_addr_i + 32'h20;
                        if (edge_cnt + 1 < err_edge) err_edge = edge_cnt + 1;
                    end
                    default: dfp_addr_i = {8'($urandom), dfp_addr_i[23:5], 5'($urandom)};
                endcase
            end
            if (k == rst_at) begin
                do_reset();
                return;
            end
            if (dfp_resp_o) begin
                seen = 1'b1;
                if (chk_lit) begin
                    check({nm, "_lat"}, 256'(k), 256'd4);
                    check({nm, "_data"}, dfp_rdata_o, lit);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout act=no_resp exp=resp_within_20", nm);
        end
    endtask

    logic [255:0] line_a, line_b, line_c, line_d, rd_data;
    initial begin
        line_a = rand_line();
        line_b = rand_line();
        line_c = rand_line();
        line_d = rand_line();

        @(negedge clk_i);
        do_reset();
        txn(0, 1, 32'h0000_1000, '0, 0, 0, -1, 1, 256'd0, "rd_cold");
        txn(1, 0, 32'h0000_1020, {8{32'hDEAD_BEEF}}, 0, 0, -1, 1, 256'd0, "wr_beef");
        txn(0, 1, 32'h0000_1020, '0, 0, 0, -1, 1, {8{32'hDEAD_BEEF}}, "rd_beef");
        txn(1, 0, 32'h0000_0000, line_a, 0, 0, -1, 1, 256'd0, "wr_a");
        txn(0, 1, 32'h0000_2000, '0, 0, 0, -1, 1, line_a, "rd_alias");
        txn(1, 1, 32'h0000_0040, line_b, 0, 0, -1, 1, 256'd0, "both");
        check("both_err", {255'd0, proto_err_o}, {255'd0, 1'b1});
        txn(0, 1, 32'h0000_0040, '0, 0, 0, -1, 1, line_b, "rd_b");

        @(negedge clk_i);
        do_reset();
        txn(1, 0, 32'h0000_1000, line_a, 0, 0, -1, 1, 256'd0, "wr_pre_drop");
        check("clean_err", {255'd0, proto_err_o}, 256'd0);
        txn(0, 1, 32'h0000_1000, '0, 1, 2, -1, 1, line_a, "drop");
        check("drop_err", {255'd0, proto_err_o}, {255'd0, 1'b1});

        @(negedge clk_i);
        do_reset();
        txn(1, 0, 32'h0000_0080, line_c, 0, 0, -1, 1, 256'd0, "wr_c");
        txn(1, 0, 32'h0000_0080, line_d, 0, 0, 1, 0, 256'd0, "wr_d_rst");
        txn(0, 1, 32'h0000_0080, '0, 0, 0, -1, 1, 256'd0, "rd_after_rst");

        @(negedge clk_i);
        do_reset();
        for (int i = 0; i < 160; i++) begin
            bit allow_err, both, wr;
            int r, ev, gap;
            logic [31:0] addr;
            allow_err = (i >= 80);
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap);
            both = allow_err && ($urandom_range(0, 19) == 0);
            wr = both || ($urandom_range(0, 1) == 1);
            addr = {19'($urandom), 8'($urandom_range(0, 15)), 5'($urandom)};
            r = $urandom_range(0, 99);
            ev = 0;
            if (allow_err && r < 6) ev = 1;
            else if (allow_err && r < 12) ev = 2;
            else if (r >= 12 && r < 20) ev = 3;
            rd_data = rand_line();
            txn(wr, both || !wr, addr, rd_data, ev,
                $urandom_range(0, (wr ? WL : RL) - 1), -1, 0, 256'd0, "rand");
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
